// File: rtl/mobo_bus_ctrl_if.sv
// mobo_bus_ctrl_if: CPU request/status and shared device bus between mobo_bus_ctrl and its environment.
interface mobo_bus_ctrl_if #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_DEV    = 4
);
    logic [WORD_WIDTH-1:0]         cpu_ctrl_i, cpu_stat_o, cpu_addr_i, cpu_data_out_i, cpu_data_in_o;
    logic [NUM_DEV*WORD_WIDTH-1:0] dev_ctrl_o, dev_stat_i;
    logic [WORD_WIDTH-1:0]         addr_o, data_in_i, data_out_o, err_addr_o;
    modport master (
        input  cpu_ctrl_i, cpu_addr_i, cpu_data_out_i, dev_stat_i, data_in_i,
        output cpu_stat_o, cpu_data_in_o, dev_ctrl_o, addr_o, data_out_o, err_addr_o
    );
    modport slave (
        output cpu_ctrl_i, cpu_addr_i, cpu_data_out_i, dev_stat_i, data_in_i,
        input  cpu_stat_o, cpu_data_in_o, dev_ctrl_o, addr_o, data_out_o, err_addr_o
    );
endinterface

// File: rtl/mobo_bus_ctrl.sv
// mobo_bus_ctrl: single-outstanding CPU-to-device bus controller with four-phase ctrl/stat handshakes.
// Define MOBO_BUS_TIMEOUT_EN to add a device response watchdog of TIMEOUT cycles.
module mobo_bus_ctrl #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_DEV    = 4,
    parameter int SEL_BITS   = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    mobo_bus_ctrl_if.master bus
);
    localparam int W = WORD_WIDTH;
    localparam logic [W-1:0] ST_IDLE = W'(0), ST_BUSY = W'(1), ST_DONE = W'(2), ST_ERR = W'(3);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RELEASE, S_DONE, S_ERR} state_t;
    state_t state_q, state_d;
    logic [W-1:0] req_q, req_d, wdata_q, wdata_d, stat_q, stat_d, rdata_q, rdata_d;
    logic [W-1:0] addr_q, addr_d, dout_q, dout_d, err_q, err_d;
    logic [1:0] op_q, op_d;
    logic [NUM_DEV*W-1:0] dctrl_q, dctrl_d;
    logic [SEL_BITS-1:0] sel;
    logic [W-1:0] sel_stat, offset;
    logic req_bad, timeout;
    assign sel      = req_q[W-1 -: SEL_BITS];
    assign offset   = {{SEL_BITS{1'b0}}, req_q[W-SEL_BITS-1:0]};
    assign sel_stat = bus.dev_stat_i[W*int'(sel) +: W];
    assign req_bad  = int'(bus.cpu_addr_i[W-1 -: SEL_BITS]) >= NUM_DEV
                      || bus.cpu_ctrl_i[W-1:2] != '0 || &bus.cpu_ctrl_i[1:0];
`ifdef MOBO_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;
    assign waiting = state_q == S_ISSUE || state_q == S_RELEASE;
    assign timeout = waiting && cnt_q == CW'(TIMEOUT - 1);
    // restarts on every entry into a waiting state
    assign cnt_d   = (waiting && state_d == state_q) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        err_d   = err_q;
        dctrl_d = '0;
        stat_d  = ST_IDLE;
        case (state_q)
            S_IDLE: if (bus.cpu_ctrl_i != '0) begin
                req_d   = bus.cpu_addr_i;
                op_d    = bus.cpu_ctrl_i[1:0];
                wdata_d = bus.cpu_data_out_i;
                state_d = req_bad ? S_ERR : S_ISSUE;
                stat_d  = req_bad ? ST_IDLE : ST_BUSY;
            end
            S_ISSUE: begin
                stat_d = ST_BUSY;
                addr_d = offset;
                dout_d = op_q[1] ? wdata_q : dout_q;
                if (timeout) begin
                    state_d = S_ERR;
                    err_d   = req_q;
                end else if (sel_stat == ST_DONE) begin
                    state_d = S_RELEASE;
                    rdata_d = op_q[0] ? bus.data_in_i : rdata_q;
                end else begin
                    dctrl_d[W*int'(sel) +: W] = W'(op_q);
                end
            end
            S_RELEASE: begin
                stat_d  = ST_BUSY;
                state_d = timeout ? S_ERR : (sel_stat == ST_IDLE) ? S_DONE : S_RELEASE;
                err_d   = timeout ? req_q : err_q;
            end
            S_DONE: begin
                stat_d  = ST_DONE;
                state_d = bus.cpu_ctrl_i == '0 ? S_IDLE : S_DONE;
            end
            S_ERR: begin
                stat_d  = ST_ERR;
                err_d   = req_q;
                state_d = bus.cpu_ctrl_i == '0 ? S_IDLE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            err_q   <= '0;
            stat_q  <= '0;
            dctrl_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            stat_q  <= stat_d;
            dctrl_q <= dctrl_d;
        end
    end
    assign bus.cpu_stat_o    = stat_q;
    assign bus.cpu_data_in_o = rdata_q;
    assign bus.dev_ctrl_o    = dctrl_q;
    assign bus.addr_o        = addr_q;
    assign bus.data_out_o    = dout_q;
    assign bus.err_addr_o    = err_q;
endmodule

// File: tb/tb_mobo_bus_ctrl.sv
// tb_mobo_bus_ctrl: directed tests of mobo_bus_ctrl with NUM_DEV=3 and a NUM_DEV=4 instance for the full address map.
module tb_mobo_bus_ctrl;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;

    mobo_bus_ctrl_if #(.WORD_WIDTH(W), .NUM_DEV(3)) b3 ();
    mobo_bus_ctrl_if #(.WORD_WIDTH(W), .NUM_DEV(4)) b4 ();

    mobo_bus_ctrl #(.WORD_WIDTH(W), .NUM_DEV(3), .SEL_BITS(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b3)
    );
    mobo_bus_ctrl #(.WORD_WIDTH(W), .NUM_DEV(4), .SEL_BITS(2), .TIMEOUT(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );

    always #5 clk = ~clk;

    task automatic wait_idle(input int n);
        for (int i = 0; i < n && b3.cpu_stat_o !== 16'd0; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        b3.cpu_ctrl_i = '0; b3.cpu_addr_i = '0; b3.cpu_data_out_i = '0; b3.dev_stat_i = '0; b3.data_in_i = '0;
        b4.cpu_ctrl_i = '0; b4.cpu_addr_i = '0; b4.cpu_data_out_i = '0; b4.dev_stat_i = '0; b4.data_in_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd0 || b3.dev_ctrl_o !== 48'd0 || b3.addr_o !== 16'd0)
            begin errors++; $display("FAIL reset_stat_ctrl_addr: got %h %h %h want 0 0 0", b3.cpu_stat_o, b3.dev_ctrl_o, b3.addr_o); end
        checks++;
        if (b3.data_out_o !== 16'd0 || b3.err_addr_o !== 16'd0 || b3.cpu_data_in_o !== 16'd0)
            begin errors++; $display("FAIL reset_data_err: got %h %h %h want 0 0 0", b3.data_out_o, b3.err_addr_o, b3.cpu_data_in_o); end
        checks++;
        if (b4.cpu_stat_o !== 16'd0 || b4.dev_ctrl_o !== 64'd0)
            begin errors++; $display("FAIL reset_dut4: got %h %h want 0 0", b4.cpu_stat_o, b4.dev_ctrl_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram_read;
        b3.cpu_ctrl_i = 16'd1; b3.cpu_addr_i = 16'h0123;
        @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd1 || b3.dev_ctrl_o !== 48'd0)
            begin errors++; $display("FAIL read_accept: stat %h ctrl %h want 1 0", b3.cpu_stat_o, b3.dev_ctrl_o); end
        @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'h0000_0000_0001 || b3.addr_o !== 16'h0123)
            begin errors++; $display("FAIL read_issue: ctrl %h addr %h want 1 0123", b3.dev_ctrl_o, b3.addr_o); end
        repeat (2) @(negedge clk);
        b3.dev_stat_i = 48'h0000_0000_0002; b3.data_in_i = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'd0 || b3.cpu_data_in_o !== 16'hBEEF || b3.cpu_stat_o !== 16'd1)
            begin errors++; $display("FAIL read_capture: ctrl %h data %h stat %h want 0 beef 1", b3.dev_ctrl_o, b3.cpu_data_in_o, b3.cpu_stat_o); end
        b3.dev_stat_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd2)
            begin errors++; $display("FAIL read_done: stat %h want 2", b3.cpu_stat_o); end
        repeat (3) @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd2 || b3.dev_ctrl_o !== 48'd0)
            begin errors++; $display("FAIL read_hold: stat %h ctrl %h want 2 0", b3.cpu_stat_o, b3.dev_ctrl_o); end
        b3.cpu_ctrl_i = '0;
        wait_idle(4);
        checks++;
        if (b3.cpu_stat_o !== 16'd0)
            begin errors++; $display("FAIL read_idle: stat %h want 0", b3.cpu_stat_o); end
    endtask

    task automatic test_write;
        b3.cpu_ctrl_i = 16'd2; b3.cpu_addr_i = 16'h4010; b3.cpu_data_out_i = 16'h00AA;
        @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd1)
            begin errors++; $display("FAIL write_accept: stat %h want 1", b3.cpu_stat_o); end
        @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'h0000_0002_0000 || b3.addr_o !== 16'h0010 || b3.data_out_o !== 16'h00AA)
            begin errors++; $display("FAIL write_issue: ctrl %h addr %h data %h want 000000020000 0010 00aa", b3.dev_ctrl_o, b3.addr_o, b3.data_out_o); end
        b3.dev_stat_i = 48'h0000_0000_0002;
        @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'h0000_0002_0000)
            begin errors++; $display("FAIL write_foreign_done: ctrl %h want 000000020000", b3.dev_ctrl_o); end
        b3.dev_stat_i = 48'h0000_0002_0000;
        @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'd0)
            begin errors++; $display("FAIL write_release: ctrl %h want 0", b3.dev_ctrl_o); end
        b3.dev_stat_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd2 || b3.cpu_data_in_o !== 16'hBEEF)
            begin errors++; $display("FAIL write_done: stat %h data %h want 2 beef", b3.cpu_stat_o, b3.cpu_data_in_o); end
        b3.cpu_ctrl_i = '0;
        wait_idle(4);
        checks++;
        if (b3.cpu_stat_o !== 16'd0 || b3.addr_o !== 16'h0010)
            begin errors++; $display("FAIL write_idle: stat %h addr %h want 0 0010", b3.cpu_stat_o, b3.addr_o); end
    endtask

    task automatic test_slow_release;
        b3.cpu_ctrl_i = 16'd1; b3.cpu_addr_i = 16'h4005;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'h0000_0001_0000 || b3.addr_o !== 16'h0005)
            begin errors++; $display("FAIL slow_issue: ctrl %h addr %h want 000000010000 0005", b3.dev_ctrl_o, b3.addr_o); end
        b3.dev_stat_i = 48'h0000_0002_0000; b3.data_in_i = 16'h1234;
        @(negedge clk);
        b3.cpu_ctrl_i = '0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (b3.cpu_stat_o !== 16'd1 || b3.dev_ctrl_o !== 48'd0)
                begin errors++; $display("FAIL slow_busy_%0d: stat %h ctrl %h want 1 0", i, b3.cpu_stat_o, b3.dev_ctrl_o); end
            @(negedge clk);
        end
        b3.dev_stat_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd2 || b3.cpu_data_in_o !== 16'h1234)
            begin errors++; $display("FAIL slow_done: stat %h data %h want 2 1234", b3.cpu_stat_o, b3.cpu_data_in_o); end
        wait_idle(4);
        checks++;
        if (b3.cpu_stat_o !== 16'd0)
            begin errors++; $display("FAIL slow_idle: stat %h want 0", b3.cpu_stat_o); end
    endtask

    task automatic test_errors;
        b3.cpu_ctrl_i = 16'd1; b3.cpu_addr_i = 16'hC000;
        @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'd0)
            begin errors++; $display("FAIL addr_err_noissue: ctrl %h want 0", b3.dev_ctrl_o); end
        @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd3 || b3.err_addr_o !== 16'hC000 || b3.dev_ctrl_o !== 48'd0)
            begin errors++; $display("FAIL addr_err: stat %h err %h ctrl %h want 3 c000 0", b3.cpu_stat_o, b3.err_addr_o, b3.dev_ctrl_o); end
        b3.cpu_ctrl_i = '0;
        wait_idle(4);
        b3.cpu_ctrl_i = 16'd3; b3.cpu_addr_i = 16'h0001;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd3 || b3.err_addr_o !== 16'h0001 || b3.dev_ctrl_o !== 48'd0)
            begin errors++; $display("FAIL op_rw_err: stat %h err %h ctrl %h want 3 0001 0", b3.cpu_stat_o, b3.err_addr_o, b3.dev_ctrl_o); end
        b3.cpu_ctrl_i = '0;
        wait_idle(4);
        b3.cpu_ctrl_i = 16'd4; b3.cpu_addr_i = 16'h0004;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd3 || b3.err_addr_o !== 16'h0004)
            begin errors++; $display("FAIL op_high_err: stat %h err %h want 3 0004", b3.cpu_stat_o, b3.err_addr_o); end
        b3.cpu_ctrl_i = '0;
        wait_idle(4);
        checks++;
        if (b3.cpu_stat_o !== 16'd0)
            begin errors++; $display("FAIL err_idle: stat %h want 0", b3.cpu_stat_o); end
    endtask

    task automatic test_reset_mid;
        b3.cpu_ctrl_i = 16'd1; b3.cpu_addr_i = 16'h0042;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'h0000_0000_0001)
            begin errors++; $display("FAIL mid_issue: ctrl %h want 1", b3.dev_ctrl_o); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (b3.dev_ctrl_o !== 48'd0 || b3.cpu_stat_o !== 16'd0 || b3.err_addr_o !== 16'd0 || b3.cpu_data_in_o !== 16'd0)
            begin errors++; $display("FAIL mid_abort: ctrl %h stat %h err %h data %h want 0 0 0 0", b3.dev_ctrl_o, b3.cpu_stat_o, b3.err_addr_o, b3.cpu_data_in_o); end
        b3.cpu_ctrl_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b3.cpu_ctrl_i = 16'd1; b3.cpu_addr_i = 16'h0077;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'h0000_0000_0001 || b3.addr_o !== 16'h0077)
            begin errors++; $display("FAIL fresh_issue: ctrl %h addr %h want 1 0077", b3.dev_ctrl_o, b3.addr_o); end
        b3.dev_stat_i = 48'h0000_0000_0002; b3.data_in_i = 16'h5A5A;
        @(negedge clk);
        b3.dev_stat_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd2 || b3.cpu_data_in_o !== 16'h5A5A)
            begin errors++; $display("FAIL fresh_done: stat %h data %h want 2 5a5a", b3.cpu_stat_o, b3.cpu_data_in_o); end
        b3.cpu_ctrl_i = '0;
        wait_idle(4);
    endtask

    task automatic test_all_ones;
        b4.cpu_ctrl_i = 16'd1; b4.cpu_addr_i = 16'hFFFF;
        repeat (2) @(negedge clk);
        checks++;
        if (b4.dev_ctrl_o !== 64'h0001_0000_0000_0000 || b4.addr_o !== 16'h3FFF)
            begin errors++; $display("FAIL ones_issue: ctrl %h addr %h want 0001000000000000 3fff", b4.dev_ctrl_o, b4.addr_o); end
        b4.dev_stat_i = 64'h0002_0000_0000_0000; b4.data_in_i = 16'hCAFE;
        @(negedge clk);
        b4.dev_stat_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (b4.cpu_stat_o !== 16'd2 || b4.cpu_data_in_o !== 16'hCAFE)
            begin errors++; $display("FAIL ones_done: stat %h data %h want 2 cafe", b4.cpu_stat_o, b4.cpu_data_in_o); end
        b4.cpu_ctrl_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (b4.cpu_stat_o !== 16'd0)
            begin errors++; $display("FAIL ones_idle: stat %h want 0", b4.cpu_stat_o); end
    endtask

`ifdef MOBO_BUS_TIMEOUT_EN
    task automatic test_timeout;
        b3.cpu_ctrl_i = 16'd1; b3.cpu_addr_i = 16'h8003;
        repeat (8) @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'h0001_0000_0000 || b3.cpu_stat_o !== 16'd1)
            begin errors++; $display("FAIL to_waiting: ctrl %h stat %h want 000100000000 1", b3.dev_ctrl_o, b3.cpu_stat_o); end
        @(negedge clk);
        checks++;
        if (b3.dev_ctrl_o !== 48'd0 || b3.err_addr_o !== 16'h8003)
            begin errors++; $display("FAIL to_abort: ctrl %h err %h want 0 8003", b3.dev_ctrl_o, b3.err_addr_o); end
        @(negedge clk);
        checks++;
        if (b3.cpu_stat_o !== 16'd3 || b3.cpu_data_in_o !== 16'h5A5A)
            begin errors++; $display("FAIL to_err: stat %h data %h want 3 5a5a", b3.cpu_stat_o, b3.cpu_data_in_o); end
        b3.cpu_ctrl_i = '0;
        wait_idle(4);
    endtask
`endif

    initial begin
        test_reset();
        test_ram_read();
        test_write();
        test_slow_release();
        test_errors();
        test_reset_mid();
        test_all_ones();
`ifdef MOBO_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
